// File: rtl/trojan_resp_analyzer_pkg.sv
// Shared types and default constants for the trojan benchmark response analyzer.
// The MISR defaults are the CRC-16-CCITT polynomial and an all-ones seed.
package trojan_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;

endpackage

// File: rtl/trojan_resp_analyzer_if.sv
// Harness-side bus of the response analyzer.
// The harness drives the run controls and per-vector data, and reads back the verdict.
interface trojan_resp_analyzer_if #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 1,
  parameter int SIG_W = 16
);
  logic              start;
  logic              abort;
  logic              vec_valid;
  logic [N_IN-1:0]   vec_idx;
  logic [N_OUT-1:0]  dut_out;
  logic [N_OUT-1:0]  golden_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     mismatch_count;
  logic [N_IN-1:0]   first_fail_idx;
  logic              first_fail_vld;
  logic              seq_err;
  logic [SIG_W-1:0]  signature;

  modport master (
    output start, abort, vec_valid, vec_idx, dut_out, golden_out,
    input  busy, done, pass, mismatch_count, first_fail_idx, first_fail_vld,
           seq_err, signature
  );

  modport slave (
    input  start, abort, vec_valid, vec_idx, dut_out, golden_out,
    output busy, done, pass, mismatch_count, first_fail_idx, first_fail_vld,
           seq_err, signature
  );
endinterface

// File: rtl/trojan_resp_analyzer_misr_reg.sv
// Multiple-input signature register: Galois-style shift with a polynomial feedback,
// and the response word XORed into the low bits on every enabled cycle.
module misr_reg #(
  parameter int               SIG_W    = 16,
  parameter int               DATA_W   = 1,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  signature
);

  logic [SIG_W-1:0] sig_next;

  assign sig_next = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? SIG_POLY : '0)
                  ^ SIG_W'(data);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (load) begin
      signature <= SIG_SEED;
    end else if (enable) begin
      signature <= sig_next;
    end
  end

endmodule

// File: rtl/trojan_resp_analyzer.sv
// Compares DUT against golden responses over one exhaustive run of 2**N_IN vectors,
// tracking mismatches, the first failing vector, vector ordering and a MISR signature.
module trojan_resp_analyzer
  import trojan_tb_pkg::*;
#(
  parameter int               N_IN     = 5,
  parameter int               N_OUT    = 1,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DEF_SIG_SEED)
) (
  input logic                   CK,
  input logic                   reset,
  trojan_resp_analyzer_if.slave bus
);

  localparam logic [N_IN:0] LAST_CNT = (N_IN + 1)'((2 ** N_IN) - 1);

  state_e          state;
  logic [N_IN:0]   acc_cnt;
  logic [N_IN-1:0] expect_idx;
  logic [N_IN:0]   mismatch_count;
  logic [N_IN-1:0] first_fail_idx;
  logic            first_fail_vld;
  logic            seq_err;
  logic            pass;

  logic            start_run;
  logic            accept;
  logic            miss;
  logic            seq_bad;
  logic            last_vec;
  logic [N_IN:0]   mc_next;

  assign start_run = bus.start && (state != RUN);
  assign accept    = bus.vec_valid && (state == RUN);
  assign miss      = (bus.dut_out != bus.golden_out);
  assign seq_bad   = (bus.vec_idx != expect_idx);
  assign last_vec  = (acc_cnt == LAST_CNT);
  assign mc_next   = mismatch_count + (N_IN + 1)'(miss);

  // Abort outranks start and any vector presented in the same cycle.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      acc_cnt        <= '0;
      expect_idx     <= '0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      seq_err        <= 1'b0;
      pass           <= 1'b0;
    end else if (bus.abort || start_run) begin
      state          <= bus.abort ? IDLE : RUN;
      acc_cnt        <= '0;
      expect_idx     <= '0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      seq_err        <= 1'b0;
      pass           <= 1'b0;
    end else if (accept) begin
      acc_cnt        <= acc_cnt + (N_IN + 1)'(1);
      expect_idx     <= expect_idx + N_IN'(1);
      mismatch_count <= mc_next;
      if (miss && !first_fail_vld) begin
        first_fail_idx <= bus.vec_idx;
        first_fail_vld <= 1'b1;
      end
      if (seq_bad) begin
        seq_err <= 1'b1;
      end
      // The verdict uses this vector's contribution, which lands on the same edge.
      if (last_vec) begin
        state <= DONE;
        pass  <= (mc_next == '0) && !(seq_err || seq_bad);
      end
    end
  end

  misr_reg #(
    .SIG_W    (SIG_W),
    .DATA_W   (N_OUT),
    .SIG_POLY (SIG_POLY),
    .SIG_SEED (SIG_SEED)
  ) u_misr (
    .CK        (CK),
    .reset     (reset),
    .clear     (bus.abort),
    .load      (start_run),
    .enable    (accept),
    .data      (bus.dut_out),
    .signature (bus.signature)
  );

  assign bus.busy           = (state == RUN);
  assign bus.done           = (state == DONE);
  assign bus.pass           = pass;
  assign bus.mismatch_count = mismatch_count;
  assign bus.first_fail_idx = first_fail_idx;
  assign bus.first_fail_vld = first_fail_vld;
  assign bus.seq_err        = seq_err;

endmodule

// File: tb/tb_trojan_resp_analyzer.sv
// Bench for trojan_resp_analyzer: table-driven directed runs, reset/abort sequences,
// and randomized runs scored against a per-run model computed from the whole vector list.
module tb_trojan_resp_analyzer;
  import trojan_tb_pkg::*;

  localparam int N_IN    = 5;
  localparam int N_OUT   = 1;
  localparam int SIG_W   = 16;
  localparam int RUN_LEN = 32;

  logic CK = 1'b0;
  logic reset = 1'b0;
  always #5 CK = ~CK;

  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             vec_valid = 1'b0;
  logic [N_IN-1:0]  vec_idx = '0;
  logic [N_OUT-1:0] dut_out = '0;
  logic [N_OUT-1:0] golden_out = '0;

  trojan_resp_analyzer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .SIG_W(SIG_W)) bus_a ();
  trojan_resp_analyzer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .SIG_W(SIG_W)) bus_z ();

  assign bus_a.start = start;      assign bus_z.start = start;
  assign bus_a.abort = abort;      assign bus_z.abort = abort;
  assign bus_a.vec_valid = vec_valid;   assign bus_z.vec_valid = vec_valid;
  assign bus_a.vec_idx = vec_idx;       assign bus_z.vec_idx = vec_idx;
  assign bus_a.dut_out = dut_out;       assign bus_z.dut_out = dut_out;
  assign bus_a.golden_out = golden_out; assign bus_z.golden_out = golden_out;

  trojan_resp_analyzer #(.N_IN(N_IN), .N_OUT(N_OUT), .SIG_W(SIG_W)) u_dut (
    .CK    (CK),
    .reset (reset),
    .bus   (bus_a)
  );

  trojan_resp_analyzer #(.N_IN(N_IN), .N_OUT(N_OUT), .SIG_W(SIG_W),
                         .SIG_SEED(16'h0000)) u_dut_z (
    .CK    (CK),
    .reset (reset),
    .bus   (bus_z)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One run's worth of stimulus.
  int r_idx[RUN_LEN];
  int r_dut[RUN_LEN];
  int r_gold[RUN_LEN];
  int r_gap[RUN_LEN];
  int r_start[RUN_LEN];

  // Reference: results follow from the full list of accepted vectors; the signature is
  // the running polynomial product sig*x mod (x^16 + poly) plus the response word.
  function automatic void model(input int seed, output int mc, output int ff, output int vld,
                                output int seq, output int pass, output int sig);
    mc = 0; ff = 0; vld = 0; seq = 0; sig = seed;
    for (int i = 0; i < RUN_LEN; i++) begin
      if (r_dut[i] != r_gold[i]) begin
        mc++;
        if (vld == 0) begin
          vld = 1;
          ff  = r_idx[i];
        end
      end
      if (r_idx[i] != i) seq = 1;
      sig = sig * 2;
      if (sig >= 65536) sig = (sig - 65536) ^ 'h1021;
      sig = sig ^ r_dut[i];
    end
    pass = (mc == 0 && seq == 0) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic set_vec(input int idx, input int d, input int g);
    vec_idx    = N_IN'(idx);
    dut_out    = N_OUT'(d);
    golden_out = N_OUT'(g);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(bus_a.busy), 0);
    check({tag, " done"}, 32'(bus_a.done), 0);
    check({tag, " pass"}, 32'(bus_a.pass), 0);
    check({tag, " mismatch_count"}, 32'(bus_a.mismatch_count), 0);
    check({tag, " first_fail_idx"}, 32'(bus_a.first_fail_idx), 0);
    check({tag, " first_fail_vld"}, 32'(bus_a.first_fail_vld), 0);
    check({tag, " seq_err"}, 32'(bus_a.seq_err), 0);
    check({tag, " signature"}, 32'(bus_a.signature), 0);
  endtask

  // Starts a run, applies the stored vectors and checks the done timing.
  task automatic drive_run(input string tag);
    int early;
    early = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, 32'(bus_a.busy), 1);
    for (int i = 0; i < RUN_LEN; i++) begin
      set_vec(r_idx[i], r_dut[i], r_gold[i]);
      vec_valid = 1'b1;
      start     = r_start[i][0];
      if (bus_a.done) early = 1;
      tick();
      vec_valid = 1'b0;
      start     = 1'b0;
      if (i == RUN_LEN - 1) begin
        check({tag, " done right after last vector"}, 32'(bus_a.done), 1);
        check({tag, " busy cleared at done"}, 32'(bus_a.busy), 0);
      end else begin
        if (bus_a.done) early = 1;
        for (int k = 0; k < r_gap[i]; k++) begin
          tick();
          if (bus_a.done) early = 1;
        end
      end
    end
    check({tag, " no early done"}, 32'(early), 0);
  endtask

  task automatic check_results(input string tag, input int mc, input int ff, input int vld,
                               input int seq, input int pass, input int sig);
    check({tag, " mismatch_count"}, 32'(bus_a.mismatch_count), 32'(mc));
    check({tag, " first_fail_idx"}, 32'(bus_a.first_fail_idx), 32'(ff));
    check({tag, " first_fail_vld"}, 32'(bus_a.first_fail_vld), 32'(vld));
    check({tag, " seq_err"}, 32'(bus_a.seq_err), 32'(seq));
    check({tag, " pass"}, 32'(bus_a.pass), 32'(pass));
    check({tag, " signature"}, 32'(bus_a.signature), 32'(sig));
  endtask

  typedef struct {
    string name;
    int    fail_a;
    int    fail_b;
    int    gap;
    int    dup_at;
    int    zero_resp;
    int    exp_mc;
    int    exp_ff;
    int    exp_vld;
    int    exp_seq;
    int    exp_pass;
  } scen_t;

  scen_t tbl[5];

  task automatic fill_scen(input scen_t s);
    for (int i = 0; i < RUN_LEN; i++) begin
      r_idx[i]   = (i == s.dup_at) ? i - 1 : i;
      r_dut[i]   = (s.zero_resp != 0) ? 0 : ((i ^ (i >> 2)) & 1);
      r_gold[i]  = r_dut[i] ^ ((i == s.fail_a || i == s.fail_b) ? 1 : 0);
      r_gap[i]   = s.gap;
      r_start[i] = 0;
    end
  endtask

  initial begin
    int mc, ff, vld, seq, pass, sig;

    tbl[0] = '{"clean",     -1, -1, 0, -1, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{"fail_5_17",  5, 17, 0, -1, 0, 2, 5, 1, 0, 0};
    tbl[2] = '{"gaps3",     -1, -1, 3, -1, 0, 0, 0, 0, 0, 1};
    tbl[3] = '{"seq_dup",   -1, -1, 0,  4, 0, 0, 0, 0, 1, 0};
    tbl[4] = '{"zero_resp", -1, -1, 0, -1, 1, 0, 0, 0, 0, 1};

    repeat (3) @(posedge CK);
    #1;
    check_idle("in reset");
    @(negedge CK);
    reset = 1'b1;
    tick();
    check_idle("after reset");

    // Directed table runs.
    foreach (tbl[t]) begin
      fill_scen(tbl[t]);
      model(16'hFFFF, mc, ff, vld, seq, pass, sig);
      drive_run(tbl[t].name);
      check_results(tbl[t].name, tbl[t].exp_mc, tbl[t].exp_ff, tbl[t].exp_vld,
                    tbl[t].exp_seq, tbl[t].exp_pass, sig);
      if (tbl[t].zero_resp != 0)
        check("zero seed zero resp signature", 32'(bus_z.signature), 0);
      tick();
    end

    // Reset in the middle of a run, at vector 10.
    fill_scen(tbl[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_vec(r_idx[i], r_dut[i], r_gold[i] ^ 1);
      vec_valid = 1'b1;
      tick();
    end
    set_vec(10, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check_idle("async reset mid-run");
    vec_valid = 1'b0;
    tick();
    @(negedge CK);
    reset = 1'b1;
    // A vector offered while idle must be ignored.
    set_vec(0, 1, 0);
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    check_idle("vector in idle");

    // Abort-on-start with a simultaneous vector after some progress.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_vec(i + 1, 1, 0);
      vec_valid = 1'b1;
      tick();
    end
    check("partial run mismatches", 32'(bus_a.mismatch_count), 3);
    start = 1'b1;
    abort = 1'b1;
    set_vec(4, 1, 0);
    vec_valid = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    vec_valid = 1'b0;
    check_idle("abort with start");
    tick();
    check_idle("abort settled");

    fill_scen(tbl[0]);
    model(16'hFFFF, mc, ff, vld, seq, pass, sig);
    drive_run("clean after abort");
    check_results("clean after abort", 0, 0, 0, 0, 1, sig);

    // Randomized runs: sparse mismatches, rare out-of-order indices, gaps, ignored starts.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < RUN_LEN; i++) begin
        r_idx[i]   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, RUN_LEN - 1)) : i;
        r_dut[i]   = int'($urandom_range(0, 1));
        r_gold[i]  = ($urandom_range(0, 9) == 0) ? (r_dut[i] ^ 1) : r_dut[i];
        r_gap[i]   = int'($urandom_range(0, 2));
        r_start[i] = ($urandom_range(0, 15) == 0) ? 1 : 0;
      end
      model(16'hFFFF, mc, ff, vld, seq, pass, sig);
      drive_run($sformatf("rand%0d", r));
      check_results($sformatf("rand%0d", r), mc, ff, vld, seq, pass, sig);
      // Results must hold in DONE while more vectors arrive.
      for (int k = 0; k < 2; k++) begin
        set_vec(7, 1, 0);
        vec_valid = 1'b1;
        tick();
      end
      vec_valid = 1'b0;
      check($sformatf("rand%0d held mismatch_count", r), 32'(bus_a.mismatch_count), 32'(mc));
      check($sformatf("rand%0d held signature", r), 32'(bus_a.signature), 32'(sig));
      check($sformatf("rand%0d still done", r), 32'(bus_a.done), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
